// File: rtl/ibex_data_bus_arbiter_pkg.sv
// Shared types for the two-master data-bus arbiter.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package ibex_data_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_FREE    = 2'd0,
        ARB_LOCK_M0 = 2'd1,
        ARB_LOCK_M1 = 2'd2
    } arb_state_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } arb_id_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_req_t;

    function automatic arb_id_e arb_other(input arb_id_e id);
        return (id == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/ibex_data_bus_arbiter_id_fifo.sv
// In-order FIFO of issuer IDs for granted-but-unanswered data-bus transactions.
// Latency: push visible at head next cycle; head is combinational from storage.
// Backpressure: full/empty come from the registered count; push when full and pop when empty are ignored.
module ibex_arb_id_fifo
    import ibex_data_bus_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  arb_id_e push_id,
    input  logic    pop,
    output arb_id_e head_id,
    output logic    full,
    output logic    empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    arb_id_e         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_id = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= M0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ibex_data_bus_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the LSU (m0) and a secondary master (m1).
// Latency: zero-cycle gnt/err/rvalid/rdata pass-through; responses return in issue order.
// Backpressure: slave request held stable until data_gnt_i; data_req_o drops while the ID FIFO is full.
module ibex_data_bus_arbiter
    import ibex_data_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic        m0_err_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic        m1_err_o,
    output logic [31:0] m1_rdata_o,

    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,

    output logic        busy_o
);

    arb_state_e state_q;
    arb_id_e    last_q;
    arb_id_e    sel;
    logic       sel_req;
    logic       granted;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    arb_id_e    head_id;
    bus_req_t   m0_fields;
    bus_req_t   m1_fields;
    bus_req_t   sel_fields;

    assign m0_fields = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
    assign m1_fields = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};

    // While locked the selection ignores the other master so the slave sees stable fields.
    always_comb begin
        sel     = M0;
        sel_req = 1'b0;
        case (state_q)
            ARB_LOCK_M0: begin
                sel     = M0;
                sel_req = m0_req_i;
            end
            ARB_LOCK_M1: begin
                sel     = M1;
                sel_req = m1_req_i;
            end
            default: begin
                if (m0_req_i && m1_req_i) begin
                    sel = arb_other(last_q);
                end else if (m1_req_i) begin
                    sel = M1;
                end else begin
                    sel = M0;
                end
                sel_req = m0_req_i || m1_req_i;
            end
        endcase
    end

    assign sel_fields   = (sel == M1) ? m1_fields : m0_fields;
    assign data_addr_o  = sel_fields.addr;
    assign data_we_o    = sel_fields.we;
    assign data_be_o    = sel_fields.be;
    assign data_wdata_o = sel_fields.wdata;

    assign data_req_o = sel_req && !fifo_full;
    assign granted    = data_req_o && data_gnt_i;

    assign m0_gnt_o = granted && (sel == M0);
    assign m1_gnt_o = granted && (sel == M1);
    assign m0_err_o = m0_gnt_o && data_err_i;
    assign m1_err_o = m1_gnt_o && data_err_i;

    // A response with nothing outstanding is dropped rather than misrouted.
    assign fifo_pop    = data_rvalid_i && !fifo_empty;
    assign m0_rvalid_o = fifo_pop && (head_id == M0);
    assign m1_rvalid_o = fifo_pop && (head_id == M1);
    assign m0_rdata_o  = data_rdata_i;
    assign m1_rdata_o  = data_rdata_i;

    assign busy_o = data_req_o || !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_FREE;
            last_q  <= M1;
        end else begin
            case (state_q)
                ARB_LOCK_M0, ARB_LOCK_M1: begin
                    if (!sel_req) begin
                        state_q <= ARB_FREE;
                    end else if (granted) begin
                        state_q <= ARB_FREE;
                        last_q  <= sel;
                    end
                end
                default: begin
                    state_q <= ARB_FREE;
                    if (granted) begin
                        last_q <= sel;
                    end else if (sel_req) begin
                        state_q <= (sel == M1) ? ARB_LOCK_M1 : ARB_LOCK_M0;
                    end
                end
            endcase
        end
    end

    ibex_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (granted),
        .push_id (sel),
        .pop     (fifo_pop),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_ibex_data_bus_arbiter.sv
// Directed bench for ibex_data_bus_arbiter with MAX_OUTSTANDING=2.
module tb_ibex_data_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_be;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic        data_req, data_gnt, data_rvalid, data_err, data_we, busy;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_be;

    int vectors;
    int miscompares;

    ibex_data_bus_arbiter #(
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m0_req_i      (m0_req),
        .m0_addr_i     (m0_addr),
        .m0_we_i       (m0_we),
        .m0_be_i       (m0_be),
        .m0_wdata_i    (m0_wdata),
        .m0_gnt_o      (m0_gnt),
        .m0_rvalid_o   (m0_rvalid),
        .m0_err_o      (m0_err),
        .m0_rdata_o    (m0_rdata),
        .m1_req_i      (m1_req),
        .m1_addr_i     (m1_addr),
        .m1_we_i       (m1_we),
        .m1_be_i       (m1_be),
        .m1_wdata_i    (m1_wdata),
        .m1_gnt_o      (m1_gnt),
        .m1_rvalid_o   (m1_rvalid),
        .m1_err_o      (m1_err),
        .m1_rdata_o    (m1_rdata),
        .data_req_o    (data_req),
        .data_gnt_i    (data_gnt),
        .data_rvalid_i (data_rvalid),
        .data_err_i    (data_err),
        .data_addr_o   (data_addr),
        .data_we_o     (data_we),
        .data_be_o     (data_be),
        .data_wdata_o  (data_wdata),
        .data_rdata_i  (data_rdata),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        m0_req = 0; m0_addr = 32'h0000_1000; m0_we = 0; m0_be = 4'hF; m0_wdata = 32'h1111_1111;
        m1_req = 0; m1_addr = 32'h0000_2000; m1_we = 1; m1_be = 4'hC; m1_wdata = 32'h5555_5555;
        data_gnt = 0; data_rvalid = 0; data_err = 0; data_rdata = 32'h0;

        // Reset state
        #2;
        chk1 ("rst_m0_gnt", m0_gnt, 1'b0);
        chk1 ("rst_m1_gnt", m1_gnt, 1'b0);
        chk1 ("rst_m0_rvalid", m0_rvalid, 1'b0);
        chk1 ("rst_m1_rvalid", m1_rvalid, 1'b0);
        chk1 ("rst_m0_err", m0_err, 1'b0);
        chk1 ("rst_m1_err", m1_err, 1'b0);
        chk1 ("rst_data_req", data_req, 1'b0);
        chk1 ("rst_busy", busy, 1'b0);
        chk32("rst_addr_m0", data_addr, 32'h0000_1000);
        chk32("rst_wdata_m0", data_wdata, 32'h1111_1111);
        cyc(); rst_n = 1'b1;

        // Single m0 read, immediate grant, response next cycle
        cyc(); m0_req = 1; data_gnt = 1; #1;
        chk1 ("t1_m0_gnt", m0_gnt, 1'b1);
        chk1 ("t1_m1_gnt", m1_gnt, 1'b0);
        chk1 ("t1_data_req", data_req, 1'b1);
        chk32("t1_addr", data_addr, 32'h0000_1000);
        cyc(); m0_req = 0; data_gnt = 0; data_rvalid = 1; data_rdata = 32'hDEAD_BEEF; #1;
        chk1 ("t1_m0_rvalid", m0_rvalid, 1'b1);
        chk32("t1_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk1 ("t1_m1_rvalid", m1_rvalid, 1'b0);
        chk1 ("t1_busy_outst", busy, 1'b1);
        cyc(); data_rvalid = 0; #1;
        chk1 ("t1_busy_idle", busy, 1'b0);

        // Both masters from reset, slave grants every cycle
        cyc(); rst_n = 1'b0;
        cyc(); rst_n = 1'b1;
        cyc(); m0_req = 1; m1_req = 1; data_gnt = 1; #1;
        chk1 ("t2a_m0_gnt", m0_gnt, 1'b1);
        chk1 ("t2a_m1_gnt", m1_gnt, 1'b0);
        cyc(); data_rvalid = 1; data_rdata = 32'hA0A0_0001; #1;
        chk1 ("t2b_m1_gnt", m1_gnt, 1'b1);
        chk32("t2b_addr", data_addr, 32'h0000_2000);
        chk1 ("t2b_m0_rvalid", m0_rvalid, 1'b1);
        chk1 ("t2b_m1_rvalid", m1_rvalid, 1'b0);
        cyc(); #1;
        chk1 ("t2c_m0_gnt", m0_gnt, 1'b1);
        chk1 ("t2c_m1_rvalid", m1_rvalid, 1'b1);
        cyc(); #1;
        chk1 ("t2d_m1_gnt", m1_gnt, 1'b1);
        chk1 ("t2d_m0_rvalid", m0_rvalid, 1'b1);
        cyc(); m0_req = 0; m1_req = 0; data_gnt = 0; #1;
        chk1 ("t2e_m1_rvalid", m1_rvalid, 1'b1);
        chk1 ("t2e_m0_rvalid", m0_rvalid, 1'b0);
        cyc(); data_rvalid = 0; #1;
        chk1 ("t2_busy_idle", busy, 1'b0);

        // m1 held without grant; m0 arrives but selection stays locked
        cyc(); m1_req = 1; #1;
        chk1 ("t3c0_data_req", data_req, 1'b1);
        chk32("t3c0_addr", data_addr, 32'h0000_2000);
        chk1 ("t3c0_we", data_we, 1'b1);
        chk32("t3c0_be", {28'h0, data_be}, 32'h0000_000C);
        cyc(); m0_req = 1; #1;
        chk32("t3c1_addr", data_addr, 32'h0000_2000);
        chk1 ("t3c1_m0_gnt", m0_gnt, 1'b0);
        cyc(); #1;
        chk32("t3c2_addr", data_addr, 32'h0000_2000);
        cyc(); data_gnt = 1; #1;
        chk32("t3c3_addr", data_addr, 32'h0000_2000);
        chk1 ("t3c3_m1_gnt", m1_gnt, 1'b1);
        chk1 ("t3c3_m0_gnt", m0_gnt, 1'b0);
        cyc(); m1_req = 0; #1;
        chk1 ("t3c4_m0_gnt", m0_gnt, 1'b1);
        chk32("t3c4_addr", data_addr, 32'h0000_1000);

        // FIFO now full: third request blocked until a response drains an entry
        cyc(); m0_req = 0; m1_req = 1; #1;
        chk1 ("t4_full_req", data_req, 1'b0);
        chk1 ("t4_full_gnt", m1_gnt, 1'b0);
        chk1 ("t4_full_busy", busy, 1'b1);
        cyc(); data_rvalid = 1; #1;
        chk1 ("t4_pop_m1_rvalid", m1_rvalid, 1'b1);
        chk1 ("t4_pop_req", data_req, 1'b0);
        chk1 ("t4_pop_gnt", m1_gnt, 1'b0);
        cyc(); data_rvalid = 0; #1;
        chk1 ("t4_issue_req", data_req, 1'b1);
        chk1 ("t4_issue_gnt", m1_gnt, 1'b1);
        cyc(); m1_req = 0; data_gnt = 0; data_rvalid = 1; #1;
        chk1 ("t4_m0_rvalid", m0_rvalid, 1'b1);
        cyc(); #1;
        chk1 ("t4_m1_rvalid", m1_rvalid, 1'b1);

        // Error routing and stray response
        cyc(); data_rvalid = 0; m1_req = 1; data_gnt = 1; data_err = 1; #1;
        chk1 ("t5_m1_err", m1_err, 1'b1);
        chk1 ("t5_m0_err", m0_err, 1'b0);
        cyc(); m1_req = 0; data_gnt = 0; data_err = 0; data_rvalid = 1; #1;
        chk1 ("t5_m1_rvalid", m1_rvalid, 1'b1);
        chk1 ("t5_err_clear", m1_err, 1'b0);
        cyc(); #1;
        chk1 ("t5_stray_m0", m0_rvalid, 1'b0);
        chk1 ("t5_stray_m1", m1_rvalid, 1'b0);
        chk1 ("t5_stray_busy", busy, 1'b0);

        // Master drops request while locked
        cyc(); data_rvalid = 0; m0_req = 1; #1;
        chk1 ("t5_lock_req", data_req, 1'b1);
        cyc(); m0_req = 0; m1_req = 1; #1;
        chk1 ("t5_drop_req", data_req, 1'b0);
        chk32("t5_drop_addr", data_addr, 32'h0000_1000);
        cyc(); data_gnt = 1; #1;
        chk32("t5_free_addr", data_addr, 32'h0000_2000);
        chk1 ("t5_free_gnt", m1_gnt, 1'b1);
        cyc(); m1_req = 0; data_gnt = 0; data_rvalid = 1; #1;
        chk1 ("t5_drain", m1_rvalid, 1'b1);

        // Reset with two outstanding
        cyc(); data_rvalid = 0; m0_req = 1; data_gnt = 1; #1;
        chk1 ("t6_g1", m0_gnt, 1'b1);
        cyc(); #1;
        chk1 ("t6_g2", m0_gnt, 1'b1);
        cyc(); m0_req = 0; data_gnt = 0; #1;
        chk1 ("t6_busy_before", busy, 1'b1);
        rst_n = 1'b0; #1;
        chk1 ("t6_busy_in_rst", busy, 1'b0);
        cyc(); rst_n = 1'b1;
        cyc(); data_rvalid = 1; #1;
        chk1 ("t6_late_m0", m0_rvalid, 1'b0);
        chk1 ("t6_late_m1", m1_rvalid, 1'b0);
        chk1 ("t6_busy_after", busy, 1'b0);
        cyc(); data_rvalid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
